// File: rtl/io_port_bank.sv
// Memory-mapped bank of output registers, synchronized input ports, change status and masked irq.
// Latency: writes reach port_out one cycle after sampling; reads return one cycle after rd_en.
// Backpressure: none, so every strobe is accepted on the edge that samples it.
module io_port_bank #(
    parameter int               WIDTH       = 32,
    parameter int               N_OUT       = 4,
    parameter int               N_IN        = 4,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 'h40000000,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_addr,
    input  logic [2:0]             wr_size,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic [N_IN*WIDTH-1:0]  port_in,
    output logic [N_OUT*WIDTH-1:0] port_out,
    output logic                   irq
);

    localparam logic [WIDTH-1:0] OFF_STATUS = WIDTH'(N_OUT + N_IN);
    localparam logic [WIDTH-1:0] OFF_MASK   = WIDTH'(N_OUT + N_IN + 1);

    logic [WIDTH-1:0]      out_q [N_OUT];
    logic [N_IN*WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [N_IN*WIDTH-1:0] prev_q;
    logic [N_IN*WIDTH-1:0] in_final;
    logic [N_IN-1:0]       status_q;
    logic [N_IN-1:0]       mask_q;
    logic [N_IN-1:0]       chg;
    logic [N_IN-1:0]       status_clr;
    logic [N_IN-1:0]       mask_wr;
    logic [WIDTH-1:0]      wr_off;
    logic [WIDTH-1:0]      rd_off;
    logic [WIDTH-1:0]      wr_mask;
    logic [WIDTH-1:0]      rd_mux;
    logic [WIDTH-1:0]      rd_data_q;
    logic                  rd_valid_q;
    logic                  irq_q;

    assign wr_off   = wr_addr - BASE_ADDR;
    assign rd_off   = rd_addr - BASE_ADDR;
    assign in_final = sync_q[SYNC_STAGES-1];

    // Lanes a write may touch; unsupported sizes touch nothing.
    always_comb begin
        wr_mask = '0;
        case (wr_size)
            3'd0:    wr_mask = WIDTH'(8'hFF);
            3'd1:    wr_mask = WIDTH'(16'hFFFF);
            3'd2:    wr_mask = '1;
            default: wr_mask = '0;
        endcase
    end

    assign mask_wr    = (mask_q & ~wr_mask[N_IN-1:0]) | (wr_data[N_IN-1:0] & wr_mask[N_IN-1:0]);
    assign status_clr = (wr_en && wr_off == OFF_STATUS) ? wr_data[N_IN-1:0] : '0;

    always_comb begin
        chg = '0;
        for (int k = 0; k < N_IN; k++)
            chg[k] = in_final[k*WIDTH +: WIDTH] != prev_q[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
            mask_q <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < N_OUT; k++)
                if (wr_off == WIDTH'(k))
                    out_q[k] <= (out_q[k] & ~wr_mask) | (wr_data & wr_mask);
            if (wr_off == OFF_MASK) mask_q <= mask_wr;
        end
    end

    generate
        for (genvar g = 0; g < N_OUT; g++) begin : g_out
            assign port_out[g*WIDTH +: WIDTH] = out_q[g];
        end
    endgenerate

    // prev_q resets with the synchronizer, so release never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= port_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= in_final;
        end
    end

    // A new edge overrides a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~status_clr) | chg;
            irq_q    <= |(status_q & mask_q);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_OUT; k++)
            if (rd_off == WIDTH'(k)) rd_mux = out_q[k];
        for (int k = 0; k < N_IN; k++)
            if (rd_off == WIDTH'(N_OUT + k)) rd_mux = in_final[k*WIDTH +: WIDTH];
        if (rd_off == OFF_STATUS) rd_mux = WIDTH'(status_q);
        if (rd_off == OFF_MASK)   rd_mux = WIDTH'(mask_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with default parameters.
module tb_io_port_bank;

    localparam logic [31:0] A_OUT0   = 32'h40000000;
    localparam logic [31:0] A_OUT1   = 32'h40000001;
    localparam logic [31:0] A_OUT2   = 32'h40000002;
    localparam logic [31:0] A_IN2    = 32'h40000006;
    localparam logic [31:0] A_STATUS = 32'h40000008;
    localparam logic [31:0] A_MASK   = 32'h40000009;
    localparam logic [31:0] A_UNMAP  = 32'h4000003F;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [31:0]  wr_addr;
    logic [2:0]   wr_size;
    logic [31:0]  wr_data;
    logic         rd_en;
    logic [31:0]  rd_addr;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic [127:0] port_in;
    logic [127:0] port_out;
    logic         irq;

    int tests = 0;
    int fails = 0;

    io_port_bank dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_size  (wr_size),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .port_in  (port_in),
        .port_out (port_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_size = size;
        wr_data = data;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; port_in = '0;
        step(); step();
        check("rst_port_out", port_out, 128'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_irq", irq, 1'b0);
        reset = 1'b1;
        step();

        // Word write to OUT[1]
        set_wr(A_OUT1, 3'd2, 32'hDEADBEEF);
        step(); wr_en = 1'b0;
        check("word_out1", port_out, 128'h00000000_00000000_DEADBEEF_00000000);

        // Sized writes to OUT[0]
        set_wr(A_OUT0, 3'd2, 32'h11223344); step();
        set_wr(A_OUT0, 3'd0, 32'hFFFFFFAB); step();
        check("byte_out0", port_out[31:0], 32'h112233AB);
        set_wr(A_OUT0, 3'd1, 32'hFFFFCDEF); step();
        check("half_out0", port_out[31:0], 32'h1122CDEF);
        set_wr(A_OUT0, 3'd5, 32'hFFFFFFFF); step();
        wr_en = 1'b0;
        check("size5_out0", port_out[31:0], 32'h1122CDEF);
        rd_en = 1'b1; rd_addr = A_OUT0; step();
        check("rd_out0_data", rd_data, 32'h1122CDEF);
        check("rd_out0_valid", rd_valid, 1'b1);
        rd_en = 1'b0; step();
        check("idle_valid", rd_valid, 1'b0);
        check("idle_hold", rd_data, 32'h1122CDEF);

        // MASK keeps only N_IN bits
        set_wr(A_MASK, 3'd2, 32'hFFFFFFF4); step(); wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = A_MASK; step(); rd_en = 1'b0;
        check("rd_mask", rd_data, 32'h4);

        // Channel 2 edge: sync, status, irq
        port_in[95:64] = 32'h5;
        step(); step();
        rd_en = 1'b1; rd_addr = A_IN2; step();
        check("rd_in2", rd_data, 32'h5);
        check("irq_not_yet", irq, 1'b0);
        rd_addr = A_STATUS; step(); rd_en = 1'b0;
        check("status_set", rd_data, 32'h4);
        check("irq_high", irq, 1'b1);

        // Set beats a simultaneous W1C
        port_in[95:64] = 32'h6;
        step(); step();
        set_wr(A_STATUS, 3'd2, 32'h4); step(); wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = A_STATUS; step(); rd_en = 1'b0;
        check("status_set_wins", rd_data, 32'h4);
        check("irq_still_high", irq, 1'b1);
        set_wr(A_STATUS, 3'd0, 32'h4); step(); wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = A_STATUS; step(); rd_en = 1'b0;
        check("status_cleared", rd_data, 32'h0);
        check("irq_low", irq, 1'b0);

        // Read-during-write returns old contents
        rd_en = 1'b1; rd_addr = A_OUT0;
        set_wr(A_OUT0, 3'd2, 32'h5); step(); wr_en = 1'b0;
        check("rdw_old", rd_data, 32'h1122CDEF);
        check("rdw_valid", rd_valid, 1'b1);
        check("rdw_written", port_out[31:0], 32'h5);
        step();
        check("rd_new", rd_data, 32'h5);
        rd_addr = A_UNMAP; step();
        check("rd_unmapped", rd_data, 32'h0);
        check("rd_unmapped_valid", rd_valid, 1'b1);
        rd_addr = A_OUT1;
        set_wr(A_OUT2, 3'd2, 32'h77); step(); wr_en = 1'b0; rd_en = 1'b0;
        check("indep_rd", rd_data, 32'hDEADBEEF);
        check("indep_wr", port_out[95:64], 32'h77);

        // Reset mid-read with live state
        port_in[95:64] = 32'h7;
        step(); step(); step(); step();
        check("pre_rst_irq", irq, 1'b1);
        rd_en = 1'b1; rd_addr = A_OUT0; step();
        check("pre_rst_valid", rd_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_port_out", port_out, 128'h0);
        check("async_rd_valid", rd_valid, 1'b0);
        check("async_rd_data", rd_data, 32'h0);
        check("async_irq", irq, 1'b0);
        rd_en = 1'b0; port_in = '0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_valid", rd_valid, 1'b0);
        check("post_rst_data", rd_data, 32'h0);
        rd_en = 1'b1; rd_addr = A_STATUS; step();
        check("post_rst_status", rd_data, 32'h0);
        rd_addr = A_MASK; step(); rd_en = 1'b0;
        check("post_rst_mask", rd_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter N_OUT, default 4, number of output port registers (1..16).
REQ-003 SHALL have parameter N_IN, default 4, number of input ports (1..16, N_IN <= WIDTH).
REQ-004 SHALL have parameter BASE_ADDR, default 'h40000000, word address of register offset 0.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (>= 2).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset; asserted when 0.
REQ-008 wr_en  input  1  write strobe, sampled at clk rise.
REQ-009 wr_addr  input  WIDTH  write word address.
REQ-010 wr_size  input  3  write size: 0 = byte, 1 = half, 2 = word; others ignored.
REQ-011 wr_data  input  WIDTH  write data, right-aligned.
REQ-012 rd_en  input  1  read strobe.
REQ-013 rd_addr  input  WIDTH  read word address.
REQ-014 rd_data  output  WIDTH  registered read data.
REQ-015 rd_valid  output  1  high the cycle rd_data is valid.
REQ-016 port_in  input  N_IN*WIDTH  asynchronous input channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-017 port_out  output  N_OUT*WIDTH  registered output channels; same packing as port_in.
REQ-018 irq  output  1  level interrupt.

Function
REQ-019 SHALL decode offset = addr - BASE_ADDR with the following map:
- 0..N_OUT-1: OUT[k], R/W.
- N_OUT..N_OUT+N_IN-1: IN[k], RO.
- N_OUT+N_IN: STATUS, W1C.
- N_OUT+N_IN+1: MASK, R/W.
REQ-020 SHALL ignore writes to unmapped or RO offsets; reads of unmapped offsets SHALL return 0 with rd_valid = 1.
REQ-021 SHALL handle OUT/MASK writes by wr_size:
- Byte: replace bits [7:0] only.
- Half: replace bits [15:0] only.
- Word: replace all bits.
- Unused bits keep their previous value.
- wr_size 3..7: no change.
REQ-022 SHALL update port_out one cycle after the write is sampled, with no other latency.
REQ-023 SHALL pass each port_in channel through SYNC_STAGES flops; IN[k] reads the final-stage value.
REQ-024 SHALL set STATUS[k] when the final-stage value of channel k differs from its value in the previous cycle (any bit change).
REQ-025 SHALL clear STATUS[k] on a STATUS write (any wr_size) with wr_data[k] = 1.
REQ-026 SHALL let set win when a set and a W1C clear of the same bit occur in the same cycle.
REQ-027 SHALL read STATUS/MASK bits >= N_IN as 0; MASK writes to those bits are discarded.
REQ-028 SHALL drive irq = |(STATUS & MASK) from flops, updated the cycle after STATUS or MASK changes.
REQ-029 SHALL have 1-cycle read latency: rd_en at edge t gives rd_data/rd_valid valid after edge t+1.
REQ-030 SHALL hold rd_valid low and rd_data at its last value when rd_en = 0.
REQ-031 SHALL return pre-write contents for a read and write to the same offset in the same cycle.
REQ-032 SHALL perform a read and a write to different offsets independently in the same cycle.

Reset
REQ-033 SHALL, while reset = 0, asynchronously clear port_out, OUT, MASK, STATUS, all synchronizer stages, the previous-value copy, rd_data, rd_valid and irq to 0.
REQ-034 SHALL not flag edges in the first cycle after reset release even if port_in != 0; the previous-value copy starts tracking from the reset value.
REQ-035 SHALL abort a read in flight when reset is asserted: rd_valid = 0 and no stale data after release.

Verification
REQ-036 Reset then word write 'hDEADBEEF to 'h40000001 -> port_out[63:32] = 'hDEADBEEF the next cycle; other channels stay 0.
REQ-037 OUT[0] = 'h11223344, byte write 'hAB -> 'h112233AB; half write 'hCDEF -> 'h1122CDEF; wr_size 5 -> unchanged.
REQ-038 port_in ch2 goes 0->5 with MASK = 'h4 -> IN[2] reads 5 after SYNC_STAGES cycles; STATUS = 'h4; irq high one cycle later.
REQ-039 STATUS = 'h4, W1C 'h4 in the same cycle ch2 changes again -> STATUS stays 'h4; a later W1C 'h4 with no change -> STATUS 0 and irq 0.
REQ-040 Read 'h40000000 while writing 'h5 there -> rd_data = old value with rd_valid = 1; next read returns 'h5; read of 'h4000003F -> 0.
REQ-041 reset pulsed low mid-read with OUT/MASK/STATUS nonzero -> all outputs 0 immediately; rd_valid = 0 after release.
